ff3_dff: RTL and testbench

Single-clock D flip-flop with asynchronous active-low reset and synchronous active-high set. It is a storage primitive for the first-test flip-flop experiments and can be dropped into any clocked datapath that needs a registered bit (or bus) with clear/preset control. The output is registered; there are no combinational paths from inputs to `q`.

---
 rtl/ff3_dff.sv | 26 ++
 tb/tb_ff3_dff.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ff3_dff.sv
// Registered bit/bus with asynchronous active-low clear and synchronous active-high preset.
// Latency: one clock (d or SET_VALUE appears on q after the capturing edge); reset acts immediately.
// Backpressure: none; q reloads on every rising edge while out of reset.
module ff3_dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}}
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  input  logic             reset,
  input  logic             set
);

  // Reset outranks set, and set outranks data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= RESET_VALUE;
    else if (set)
      q <= SET_VALUE;
    else
      q <= d;
  end

endmodule

// File: tb/tb_ff3_dff.sv
// Self-checking bench for ff3_dff: default 1-bit, 8-bit 00/FF and 8-bit 3C/C3 variants side by side.
module tb_ff3_dff;

  localparam logic [7:0] RV_C = 8'h3C;
  localparam logic [7:0] SV_C = 8'hC3;

  logic       clk;
  logic       reset;
  logic       set;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;
  logic [7:0] qc;

  int n_cmp;
  int n_err;

  ff3_dff dut_a (.q(q1), .clk(clk), .d(d8[0]), .reset(reset), .set(set));

  ff3_dff #(.WIDTH(8), .RESET_VALUE(8'h00), .SET_VALUE(8'hFF)) dut_b (
    .q(q8), .clk(clk), .d(d8), .reset(reset), .set(set));

  ff3_dff #(.WIDTH(8), .RESET_VALUE(RV_C), .SET_VALUE(SV_C)) dut_c (
    .q(qc), .clk(clk), .d(d8), .reset(reset), .set(set));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] din;
    logic       exp1;
    logic [7:0] exp8;
    logic [7:0] expc;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic e1, input logic [7:0] e8,
                           input logic [7:0] ec);
    check({name, "_w1"}, {7'd0, q1}, {7'd0, e1});
    check({name, "_w8"}, q8, e8);
    check({name, "_c8"}, qc, ec);
  endtask

  task automatic cycle(input logic r, input logic s, input logic [7:0] dv);
    @(negedge clk);
    reset = r;
    set   = s;
    d8    = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       r, s, e1;
    logic [7:0] dv, e8, ec;
    n_cmp = 0;
    n_err = 0;
    set   = 1'b1;
    d8    = 8'hFF;
    reset = 1'b1;

    vec[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5, 8'hA5};
    vec[1] = '{1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A, 8'h5A};
    vec[2] = '{1'b1, 1'b1, 8'h00, 1'b1, 8'hFF, SV_C};
    vec[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vec[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, RV_C};
    vec[5] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, SV_C};
    vec[6] = '{1'b1, 1'b0, 8'h81, 1'b1, 8'h81, 8'h81};
    vec[7] = '{1'b0, 1'b0, 8'h7E, 1'b0, 8'h00, RV_C};
    vec[8] = '{1'b1, 1'b0, 8'h7E, 1'b0, 8'h7E, 8'h7E};
    vec[9] = '{1'b1, 1'b1, 8'h7E, 1'b1, 8'hFF, SV_C};

    // Reset asserted before any clock edge, with set and d both pushing towards SET.
    #2;
    reset = 1'b0;
    #1;
    check_all("reset_noclk", 1'b0, 8'h00, RV_C);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("reset_hold", 1'b0, 8'h00, RV_C);
    end

    foreach (vec[i]) begin
      cycle(vec[i].rst, vec[i].st, vec[i].din);
      check_all($sformatf("vec%0d", i), vec[i].exp1, vec[i].exp8, vec[i].expc);
    end

    // Set must wait for an edge; then dropping it lets d through.
    cycle(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    set = 1'b1;
    #1;
    check_all("set_before_edge", 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check_all("set_after_edge", 1'b1, 8'hFF, SV_C);
    cycle(1'b1, 1'b0, 8'h00);
    check_all("set_drop", 1'b0, 8'h00, 8'h00);

    // d toggling between edges must not reach q.
    cycle(1'b1, 1'b0, 8'hA5);
    d8 = 8'h5A;
    #2;
    d8 = 8'h0F;
    #1;
    check_all("d_toggle_hold", 1'b1, 8'hA5, 8'hA5);

    // Reset asserted mid-cycle takes effect before the next edge.
    @(posedge clk);
    #3;
    check_all("pre_async", 1'b1, 8'h0F, 8'h0F);
    reset = 1'b0;
    #1;
    check_all("async_mid", 1'b0, 8'h00, RV_C);
    @(posedge clk);
    #1;
    check_all("async_held", 1'b0, 8'h00, RV_C);

    // A set pulse that misses every rising edge is ignored.
    cycle(1'b1, 1'b0, 8'h33);
    @(negedge clk);
    set = 1'b1;
    #2;
    set = 1'b0;
    @(posedge clk);
    #1;
    check_all("set_glitch", 1'b1, 8'h33, 8'h33);

    // Randomised run against the priority rules.
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 7) != 0);
      s  = ($urandom_range(0, 3) == 0);
      dv = 8'($urandom());
      if (!r) begin
        e8 = 8'h00; ec = RV_C; e1 = 1'b0;
      end else if (s) begin
        e8 = 8'hFF; ec = SV_C; e1 = 1'b1;
      end else begin
        e8 = dv; ec = dv; e1 = dv[0];
      end
      cycle(r, s, dv);
      check_all("random", e1, e8, ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
